neureka_streamer_sched: RTL and testbench
=========================================

NEUREKA_STREAMER_SCHED -- requirements
Module: neureka_streamer_sched

Interface
REQ-001 SHALL have parameter NB_LD, default 4, meaning number of load requesters (0 feat, 1 weight, 2 norm, 3 streamin).
REQ-002 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin among loads, 0 = fixed priority (lowest index wins).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 clear_i  in  1  synchronous soft clear; returns the block to reset state.
REQ-006 enable_i  in  1  when 0, the FSM holds state and no new grant is issued.
REQ-007 ld_req_i  in  NB_LD  level load requests, held until ack.
REQ-008 st_req_i  in  1  level store request, held until ack.
REQ-009 wmem_sel_i  in  1  weight load uses the dedicated weight-memory port.
REQ-010 ack_o  out  NB_LD+1  one-cycle completion pulse per requester (bit NB_LD = store).
REQ-011 ld_st_mux_sel_o  out  1  0 = load path, 1 = store path.
REQ-012 ld_which_mux_sel_o  out  ld_which_t  selected load kind (shared package enum).
REQ-013 wmem_sel_o  out  1  registered copy of wmem_sel_i, latched at grant.
REQ-014 clear_source_o, clear_sink_o, clear_fifo_o  out  1 each  one-cycle clear pulses.
REQ-015 start_o  out  1  one-cycle start pulse to the granted source/sink address generator.
REQ-016 src_done_i, sink_done_i, fifo_empty_i  in  1 each  completion flags from source, sink, TCDM FIFO.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SWITCH, START, RUN, DRAIN.
REQ-019 IDLE: if enable_i and any request is pending, latch the grant and go to SWITCH in the next cycle; otherwise stay.
REQ-020 Arbitration: st_req_i SHALL beat every load; among loads, RR_EN=1 rotates priority starting at index last_grant+1 (mod NB_LD), and RR_EN=0 uses fixed priority.
REQ-021 SWITCH (1 cycle): drive new mux selects; pulse clear_source_o for a load or clear_sink_o for a store; pulse clear_fifo_o only if the ld/st direction changed since the previous transfer.
REQ-022 START (1 cycle): pulse start_o; go to RUN.
REQ-023 RUN: wait for src_done_i (load) or sink_done_i (store); then go to DRAIN.
REQ-024 DRAIN: wait for fifo_empty_i; then pulse ack_o for the granted requester and go to IDLE in the same cycle; the minimum grant-to-ack latency is 4 cycles.
REQ-025 Done flags arriving in SWITCH or START SHALL be ignored; only RUN samples them.
REQ-026 Mux select outputs SHALL remain stable from SWITCH through DRAIN; request changes mid-transfer SHALL NOT alter them.
REQ-027 A request dropped before ack SHALL NOT abort the transfer; the ack is still issued.
REQ-028 A weight grant with wmem_sel_i=1 SHALL set wmem_sel_o=1; any other grant SHALL clear wmem_sel_o.
REQ-029 enable_i=0 in RUN/DRAIN SHALL freeze the state; done flags seen while frozen SHALL be ignored.
REQ-030 A clear_i held during a transfer SHALL return the FSM to IDLE with no ack issued.

Reset
REQ-031 Reset and clear_i SHALL set: state IDLE, ld_st_mux_sel_o=0, ld_which_mux_sel_o=LD_FEAT_SEL, wmem_sel_o=0, all pulses and ack_o 0, busy_o=0, last_grant=NB_LD-1, prev_dir=load.

Structure
REQ-032 ld_which_t values and the FSM state enum SHALL reside in neureka_package.
REQ-033 The round-robin arbiter SHALL be a separate sub-module, neureka_rr_arbiter, parameterised by NB_LD and RR_EN.

Verification
REQ-034 After reset, with ld_req_i=0001 and src_done_i asserted 3 cycles after start_o, and fifo_empty_i=1 throughout, the bench SHALL see ack_o[0] 6 cycles after the request and no clear_fifo_o pulse.
REQ-035 With ld_req_i=1111 held and RR_EN=1, the bench SHALL see grants in the order 0,1,2,3,0.
REQ-036 Raising st_req_i together with ld_req_i=0010 SHALL grant the store first; the following load grant SHALL pulse clear_fifo_o once.
REQ-037 Holding fifo_empty_i=0 for 5 cycles after src_done_i SHALL delay ack_o by exactly 5 cycles while busy_o stays 1.
REQ-038 Pulsing clear_i in RUN SHALL give busy_o=0 the next cycle and no ack_o pulse.
REQ-039 A weight request with wmem_sel_i=1 SHALL give wmem_sel_o=1 and ld_which_mux_sel_o=LD_WEIGHT_SEL from SWITCH through DRAIN.

Source files
------------

// File: rtl/neureka_streamer_sched_pkg.sv
// Shared types for the streamer scheduler.
//   ld_which_t    : load-kind select driven onto the load-path mux.
//   sched_state_e : scheduler FSM states.
//   idx_width()   : index width for a requester count (minimum 1 bit).
package neureka_package;

  localparam int unsigned LdWhichW    = 2;
  localparam int unsigned LdWeightIdx = 1;

  typedef enum logic [LdWhichW-1:0] {
    LD_FEAT_SEL     = 2'd0,
    LD_WEIGHT_SEL   = 2'd1,
    LD_NORM_SEL     = 2'd2,
    LD_STREAMIN_SEL = 2'd3
  } ld_which_t;

  typedef enum logic [2:0] {
    StIdle,
    StSwitch,
    StStart,
    StRun,
    StDrain
  } sched_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neureka_rr_arbiter.sv
// Combinational load arbiter.
//   req_i   : pending load requests, one bit per requester.
//   last_i  : index of the most recently granted load.
//   idx_o   : winning requester index (valid only when valid_o).
//   valid_o : at least one request is pending.
// RR_EN=1 searches from last_i+1 upwards (wrapping); RR_EN=0 picks the lowest index.
module neureka_rr_arbiter
  import neureka_package::*;
#(
  parameter int unsigned NB_LD = 4,
  parameter bit          RR_EN = 1'b1,
  localparam int unsigned IdxW = idx_width(NB_LD)
) (
  input  logic [NB_LD-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned w_cand;
    logic [IdxW-1:0] w_idx;
    w_cand  = 0;
    w_idx   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned off = 0; off < NB_LD; off++) begin
      if (RR_EN) begin
        w_cand = (32'(last_i) + off + 1) % NB_LD;
      end else begin
        w_cand = off;
      end
      w_idx = IdxW'(w_cand);
      if (!valid_o && req_i[w_idx]) begin
        valid_o = 1'b1;
        idx_o   = w_idx;
      end
    end
  end

endmodule

// File: rtl/neureka_streamer_sched.sv
// Streamer scheduler: arbitrates load/store requests and sequences one transfer
// at a time through SWITCH -> START -> RUN -> DRAIN.
//   clk_i, rst_ni, clear_i     : clock, async active-low reset, sync soft clear.
//   enable_i                   : 0 freezes the FSM and blocks new grants.
//   ld_req_i, st_req_i         : level requests, held until ack.
//   wmem_sel_i                 : weight load goes through the weight-memory port.
//   src_done_i, sink_done_i    : address generator completion flags.
//   fifo_empty_i               : TCDM FIFO drained.
//   ack_o                      : completion pulse per requester (MSB = store).
//   ld_st_mux_sel_o, ld_which_mux_sel_o, wmem_sel_o : path selects, stable per transfer.
//   clear_source_o, clear_sink_o, clear_fifo_o, start_o : one-cycle control pulses.
//   busy_o                     : FSM not idle.
module neureka_streamer_sched
  import neureka_package::*;
#(
  parameter int unsigned NB_LD = 4,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [NB_LD-1:0] ld_req_i,
  input  logic             st_req_i,
  input  logic             wmem_sel_i,
  output logic [NB_LD:0]   ack_o,
  output logic             ld_st_mux_sel_o,
  output ld_which_t        ld_which_mux_sel_o,
  output logic             wmem_sel_o,
  output logic             clear_source_o,
  output logic             clear_sink_o,
  output logic             clear_fifo_o,
  output logic             start_o,
  input  logic             src_done_i,
  input  logic             sink_done_i,
  input  logic             fifo_empty_i,
  output logic             busy_o
);

  localparam int unsigned IdxW = idx_width(NB_LD);
  localparam logic [IdxW-1:0] LastRst = IdxW'(NB_LD - 1);

  sched_state_e    r_state_q, w_state_d;
  logic            r_ld_st_q;     // direction of the current/last transfer (1 = store)
  logic            r_prev_dir_q;  // direction of the transfer before it
  ld_which_t       r_which_q;
  logic            r_wmem_q;
  logic [IdxW-1:0] r_last_q;      // last granted load index, also the load ack index

  logic [IdxW-1:0] w_arb_idx;
  logic            w_arb_valid;
  logic            w_grant;
  logic            w_done;

  neureka_rr_arbiter #(
    .NB_LD (NB_LD),
    .RR_EN (RR_EN)
  ) u_arb (
    .req_i   (ld_req_i),
    .last_i  (r_last_q),
    .idx_o   (w_arb_idx),
    .valid_o (w_arb_valid)
  );

  assign w_grant = (r_state_q == StIdle) && enable_i && !clear_i && (st_req_i || w_arb_valid);
  assign w_done  = r_ld_st_q ? sink_done_i : src_done_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= StIdle;
    end else begin
      r_state_q <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      StIdle:   if (w_grant) w_state_d = StSwitch;
      StSwitch: if (enable_i) w_state_d = StStart;
      StStart:  if (enable_i) w_state_d = StRun;
      StRun:    if (enable_i && w_done) w_state_d = StDrain;
      StDrain:  if (enable_i && fifo_empty_i) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (clear_i) w_state_d = StIdle;
  end

  // Grant latch: selects only change on a new grant, so they stay put for the whole transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ld_st_q    <= 1'b0;
      r_prev_dir_q <= 1'b0;
      r_which_q    <= LD_FEAT_SEL;
      r_wmem_q     <= 1'b0;
      r_last_q     <= LastRst;
    end else if (clear_i) begin
      r_ld_st_q    <= 1'b0;
      r_prev_dir_q <= 1'b0;
      r_which_q    <= LD_FEAT_SEL;
      r_wmem_q     <= 1'b0;
      r_last_q     <= LastRst;
    end else if (w_grant) begin
      r_prev_dir_q <= r_ld_st_q;
      if (st_req_i) begin
        r_ld_st_q <= 1'b1;
        r_wmem_q  <= 1'b0;
      end else begin
        r_ld_st_q <= 1'b0;
        r_which_q <= ld_which_t'(LdWhichW'(w_arb_idx));
        r_wmem_q  <= wmem_sel_i && (w_arb_idx == IdxW'(LdWeightIdx));
        r_last_q  <= w_arb_idx;
      end
    end
  end

  // Outputs; pulses are suppressed on frozen cycles so each fires exactly once.
  always_comb begin
    clear_source_o = 1'b0;
    clear_sink_o   = 1'b0;
    clear_fifo_o   = 1'b0;
    start_o        = 1'b0;
    ack_o          = '0;
    unique case (r_state_q)
      StSwitch: begin
        clear_source_o = enable_i && !r_ld_st_q;
        clear_sink_o   = enable_i && r_ld_st_q;
        clear_fifo_o   = enable_i && (r_ld_st_q != r_prev_dir_q);
      end
      StStart: start_o = enable_i;
      StDrain: begin
        if (enable_i && fifo_empty_i && !clear_i) begin
          if (r_ld_st_q) ack_o[NB_LD] = 1'b1;
          else           ack_o[r_last_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy_o             = (r_state_q != StIdle);
  assign ld_st_mux_sel_o    = r_ld_st_q;
  assign ld_which_mux_sel_o = r_which_q;
  assign wmem_sel_o         = r_wmem_q;

endmodule

// File: tb/tb_neureka_streamer_sched.sv
// Self-checking bench for neureka_streamer_sched: directed scenarios followed by
// randomized transfers, each cycle compared against a transaction-level model.
module tb_neureka_streamer_sched;
  import neureka_package::*;

  localparam int unsigned NB_LD = 4;
  localparam bit          RR_EN = 1'b1;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             clear_i;
  logic             enable_i;
  logic [NB_LD-1:0] ld_req_i;
  logic             st_req_i;
  logic             wmem_sel_i;
  logic [NB_LD:0]   ack_o;
  logic             ld_st_mux_sel_o;
  ld_which_t        ld_which_mux_sel_o;
  logic             wmem_sel_o;
  logic             clear_source_o;
  logic             clear_sink_o;
  logic             clear_fifo_o;
  logic             start_o;
  logic             src_done_i;
  logic             sink_done_i;
  logic             fifo_empty_i;
  logic             busy_o;

  always #5 clk_i = ~clk_i;

  neureka_streamer_sched #(
    .NB_LD (NB_LD),
    .RR_EN (RR_EN)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .clear_i            (clear_i),
    .enable_i           (enable_i),
    .ld_req_i           (ld_req_i),
    .st_req_i           (st_req_i),
    .wmem_sel_i         (wmem_sel_i),
    .ack_o              (ack_o),
    .ld_st_mux_sel_o    (ld_st_mux_sel_o),
    .ld_which_mux_sel_o (ld_which_mux_sel_o),
    .wmem_sel_o         (wmem_sel_o),
    .clear_source_o     (clear_source_o),
    .clear_sink_o       (clear_sink_o),
    .clear_fifo_o       (clear_fifo_o),
    .start_o            (start_o),
    .src_done_i         (src_done_i),
    .sink_done_i        (sink_done_i),
    .fifo_empty_i       (fifo_empty_i),
    .busy_o             (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the selects should currently show and who goes next.
  bit         m_ld_st;
  logic [1:0] m_which;
  bit         m_wmem;
  int         m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ld_st = 1'b0;
    m_which = 2'd0;
    m_wmem  = 1'b0;
    m_last  = NB_LD - 1;
  endfunction

  // Store wins; otherwise scan loads starting after the last grant (or from 0).
  function automatic int model_pick(input logic [NB_LD-1:0] ld, input bit st);
    int idx;
    if (st) return NB_LD;
    for (int i = 1; i <= NB_LD; i++) begin
      idx = RR_EN ? (m_last + i) % NB_LD : i - 1;
      if (ld[idx]) return idx;
    end
    return -1;
  endfunction

  // Packed layout: busy, start, clr_src, clr_sink, clr_fifo, ack, ld_st, which, wmem
  function automatic logic [31:0] exp_vec(input bit busy, input bit start, input bit cs,
                                          input bit ck, input bit cf, input logic [NB_LD:0] ack);
    return 32'({busy, start, cs, ck, cf, ack, m_ld_st, m_which, m_wmem});
  endfunction

  function automatic logic [31:0] obs_vec();
    return 32'({busy_o, start_o, clear_source_o, clear_sink_o, clear_fifo_o, ack_o,
                ld_st_mux_sel_o, 2'(ld_which_mux_sel_o), wmem_sel_o});
  endfunction

  task automatic misc_random();
    src_done_i   = 1'($urandom);
    sink_done_i  = 1'($urandom);
    fifo_empty_i = 1'($urandom);
    wmem_sel_i   = 1'($urandom);
  endtask

  task automatic drive_req(input logic [NB_LD-1:0] ld, input bit st, input bit scramble);
    if (scramble) begin
      ld_req_i = NB_LD'($urandom);
      st_req_i = 1'($urandom);
    end else begin
      ld_req_i = ld;
      st_req_i = st;
    end
  endtask

  // Idle hold cycles, grant cycle, SWITCH and START. Returns the expected grantee.
  task automatic xfer_head(input logic [NB_LD-1:0] ld, input bit st, input bit wm,
                           input int n_hold, input bit scramble, output int g);
    bit cf;
    for (int h = 0; h < n_hold; h++) begin
      @(negedge clk_i);
      misc_random();
      enable_i = 1'b0;
      ld_req_i = ld;
      st_req_i = st;
      #1 check("idle_hold", obs_vec(), exp_vec(0, 0, 0, 0, 0, '0));
    end
    g = model_pick(ld, st);
    @(negedge clk_i);
    misc_random();
    enable_i   = 1'b1;
    ld_req_i   = ld;
    st_req_i   = st;
    wmem_sel_i = wm;
    #1 check("idle_grant", obs_vec(), exp_vec(0, 0, 0, 0, 0, '0));
    cf = (st != m_ld_st);
    if (st) begin
      m_ld_st = 1'b1;
      m_wmem  = 1'b0;
    end else begin
      m_ld_st = 1'b0;
      m_which = g[1:0];
      m_wmem  = wm && (g == 1);
      m_last  = g;
    end
    // Done flags are randomized here on purpose: they must not matter yet.
    @(negedge clk_i);
    misc_random();
    drive_req(ld, st, scramble);
    enable_i = 1'b1;
    #1 check("switch", obs_vec(), exp_vec(1, 0, !st, st, cf, '0));
    @(negedge clk_i);
    misc_random();
    drive_req(ld, st, scramble);
    enable_i = 1'b1;
    #1 check("start", obs_vec(), exp_vec(1, 1, 0, 0, 0, '0));
  endtask

  task automatic set_done(input bit st, input bit v);
    if (st) sink_done_i = v;
    else    src_done_i  = v;
  endtask

  task automatic xfer(input logic [NB_LD-1:0] ld, input bit st, input bit wm, input int d_run,
                      input int d_drain, input int n_hold, input bit scramble);
    int g;
    logic [NB_LD:0] ack_exp;
    xfer_head(ld, st, wm, n_hold, scramble, g);
    ack_exp    = '0;
    ack_exp[g] = 1'b1;
    for (int k = 0; k < d_run; k++) begin
      @(negedge clk_i);
      misc_random();
      drive_req(ld, st, scramble);
      enable_i = scramble ? 1'($urandom) : 1'b1;
      if (enable_i) set_done(st, 1'b0);
      #1 check("run_wait", obs_vec(), exp_vec(1, 0, 0, 0, 0, '0));
    end
    @(negedge clk_i);
    misc_random();
    drive_req(ld, st, scramble);
    enable_i = 1'b1;
    set_done(st, 1'b1);
    #1 check("run_done", obs_vec(), exp_vec(1, 0, 0, 0, 0, '0));
    for (int k = 0; k < d_drain; k++) begin
      @(negedge clk_i);
      misc_random();
      drive_req(ld, st, scramble);
      enable_i = scramble ? 1'($urandom) : 1'b1;
      if (enable_i) fifo_empty_i = 1'b0;
      #1 check("drain_wait", obs_vec(), exp_vec(1, 0, 0, 0, 0, '0));
    end
    @(negedge clk_i);
    misc_random();
    drive_req(ld, st, scramble);
    enable_i     = 1'b1;
    fifo_empty_i = 1'b1;
    #1 check("drain_ack", obs_vec(), exp_vec(1, 0, 0, 0, 0, ack_exp));
  endtask

  // Abort a transfer with clear_i in RUN or in DRAIN (with the FIFO already empty).
  task automatic xfer_clear(input logic [NB_LD-1:0] ld, input bit st, input bit wm,
                            input bit in_drain);
    int g;
    xfer_head(ld, st, wm, 0, 1'b0, g);
    if (in_drain) begin
      @(negedge clk_i);
      misc_random();
      enable_i = 1'b1;
      set_done(st, 1'b1);
      #1 check("run_done", obs_vec(), exp_vec(1, 0, 0, 0, 0, '0));
    end
    @(negedge clk_i);
    misc_random();
    enable_i     = 1'b1;
    fifo_empty_i = 1'b1;
    clear_i      = 1'b1;
    #1 check("clear_cycle", obs_vec(), exp_vec(1, 0, 0, 0, 0, '0));
    model_reset();
    @(negedge clk_i);
    misc_random();
    clear_i  = 1'b0;
    enable_i = 1'b1;
    ld_req_i = '0;
    st_req_i = 1'b0;
    #1 check("after_clear", obs_vec(), exp_vec(0, 0, 0, 0, 0, '0));
  endtask

  task automatic clear_idle();
    @(negedge clk_i);
    misc_random();
    clear_i  = 1'b1;
    enable_i = 1'b1;
    ld_req_i = NB_LD'($urandom);
    st_req_i = 1'($urandom);
    #1 check("clear_idle", obs_vec(), exp_vec(0, 0, 0, 0, 0, '0));
    model_reset();
    @(negedge clk_i);
    clear_i  = 1'b0;
    enable_i = 1'b0;
    #1 check("after_clear_idle", obs_vec(), exp_vec(0, 0, 0, 0, 0, '0));
  endtask

  initial begin
    logic [NB_LD-1:0] ld;
    bit st;
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    enable_i     = 1'b0;
    ld_req_i     = '0;
    st_req_i     = 1'b0;
    wmem_sel_i   = 1'b0;
    src_done_i   = 1'b0;
    sink_done_i  = 1'b0;
    fifo_empty_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_i);
    #1 check("reset", obs_vec(), exp_vec(0, 0, 0, 0, 0, '0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single feature load: done 3 cycles after start, ack 6 cycles after request.
    xfer(4'b0001, 1'b0, 1'b0, 2, 0, 0, 1'b0);

    // Round-robin with all loads held.
    clear_idle();
    for (int i = 0; i < 5; i++) begin
      xfer(4'b1111, 1'b0, 1'b0, 1, 0, 0, 1'b0);
      check("rr_order", 32'(ld_which_mux_sel_o), 32'(i % 4));
    end

    // Store beats a load; the following load flips direction again.
    xfer(4'b0010, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    check("store_ack_first", 32'(ld_st_mux_sel_o), 32'd1);
    xfer(4'b0010, 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // FIFO not empty for 5 cycles.
    xfer(4'b0001, 1'b0, 1'b0, 0, 5, 0, 1'b0);

    // Clear during RUN.
    xfer_clear(4'b0100, 1'b0, 1'b0, 1'b0);

    // Weight load through the weight-memory port.
    xfer(4'b0010, 1'b0, 1'b1, 1, 1, 0, 1'b0);
    check("wmem_kept", 32'(wmem_sel_o), 32'd1);

    // Enable low in IDLE holds off the grant.
    xfer(4'b1000, 1'b0, 1'b0, 0, 0, 3, 1'b0);

    for (int t = 0; t < 150; t++) begin
      ld = NB_LD'($urandom);
      st = ($urandom_range(0, 3) == 0);
      if (ld == '0 && !st) ld[$urandom_range(0, NB_LD - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        xfer_clear(ld, st, 1'($urandom), 1'($urandom));
      end else begin
        xfer(ld, st, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 3),
             $urandom_range(0, 2), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
